// File: rtl/neuro_pkg.sv
// Shared definitions for the spike encoder: FSM states, frame length and
// maximal-length LFSR tap masks for widths 3..8.
package neuro_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A frame visits every non-zero LFSR state exactly once.
    function automatic int frame_len(input int width);
        return (1 << width) - 1;
    endfunction

    localparam int FRAME_LEN = frame_len(8);

    // Feedback taps (bit n-1 for term x^n) of primitive polynomials.
    function automatic logic [7:0] lfsr_taps(input int width);
        case (width)
            3:       return 8'h06;
            4:       return 8'h0C;
            5:       return 8'h14;
            6:       return 8'h30;
            7:       return 8'h60;
            default: return 8'hB8;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// WIDTH-bit Fibonacci LFSR; clear reloads the seed 1 and wins over enable.
module lfsr_gen
    import neuro_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] value
);

    localparam logic [7:0]       TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] value_next;
    logic             feedback;

    assign feedback   = ^(value_reg & TAPS);
    assign value_next = {value_reg[WIDTH-2:0], feedback};
    assign value      = value_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_reg <= SEED;
        end else if (clear) begin
            value_reg <= SEED;
        end else if (enable) begin
            value_reg <= value_next;
        end
    end

endmodule

// File: rtl/spike_encoder.sv
// Rate encoder: each channel emits exactly val ones per 2^WIDTH-1 cycle frame
// by comparing a shared LFSR against its latched value.
module spike_encoder
    import neuro_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [HEIGHT*WIDTH-1:0] load_data,
    output logic [HEIGHT-1:0]       spikes,
    output logic                    frame_active,
    output logic                    frame_done
);

    localparam int               FLEN     = frame_len(WIDTH);
    localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(FLEN - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] lfsr_value;
    logic             last_cycle;
    logic             accept;
    logic             running;

    assign running      = (state_reg == RUN);
    assign last_cycle   = running && (cnt_reg == LAST_CNT);
    assign load_ready   = !running || last_cycle;
    assign accept       = load_valid && load_ready;
    assign frame_active = running;
    assign frame_done   = last_cycle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // An accepted load always restarts a frame, even on the last cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_next = '0;
                end else if (last_cycle) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    lfsr_gen #(
        .WIDTH(WIDTH)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .enable(running),
        .value (lfsr_value)
    );

    generate
        for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_chan
            logic [WIDTH-1:0] val_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    val_reg <= '0;
                end else if (accept) begin
                    val_reg <= load_data[gi*WIDTH +: WIDTH];
                end
            end

            assign spikes[gi] = running && (lfsr_value <= val_reg);
        end
    endgenerate

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder: expected per-channel spike counts are
// queued at load time and compared against frames collected by a monitor.
module tb_spike_encoder;

    localparam int W  = 8;
    localparam int H  = 7;
    localparam int FL = 255;

    typedef struct {
        int cnt [H];
        int len;
    } frame_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           load_valid = 1'b0;
    logic [H*W-1:0] load_data = '0;
    logic           load_ready;
    logic [H-1:0]   spikes;
    logic           frame_active;
    logic           frame_done;

    logic           load_valid3 = 1'b0;
    logic [H*3-1:0] load_data3 = '0;
    logic           load_ready3;
    logic [H-1:0]   spikes3;
    logic           frame_active3;
    logic           frame_done3;

    int vectors = 0;
    int miscompares = 0;

    frame_t exp_q[$];
    frame_t obs_q[$];
    int     run_q[$];
    frame_t acc;
    int     run_len = 0;

    spike_encoder #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .spikes      (spikes),
        .frame_active(frame_active),
        .frame_done  (frame_done)
    );

    spike_encoder #(.WIDTH(3), .HEIGHT(H)) dut3 (
        .clk         (clk),
        .rst         (rst_n),
        .load_valid  (load_valid3),
        .load_ready  (load_ready3),
        .load_data   (load_data3),
        .spikes      (spikes3),
        .frame_active(frame_active3),
        .frame_done  (frame_done3)
    );

    always #5 clk = ~clk;

    // Monitor: accumulates spike counts per frame and contiguous active runs.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < H; j++) acc.cnt[j] = 0;
            acc.len = 0;
            run_len = 0;
        end else if (frame_active) begin
            for (int j = 0; j < H; j++) acc.cnt[j] += int'(spikes[j]);
            acc.len++;
            run_len++;
            if (frame_done) begin
                obs_q.push_back(acc);
                for (int j = 0; j < H; j++) acc.cnt[j] = 0;
                acc.len = 0;
            end
        end else if (run_len > 0) begin
            run_q.push_back(run_len);
            run_len = 0;
        end
    end

    function automatic logic [H*W-1:0] pack(input int a0, a1, a2, a3, a4, a5, a6);
        return {a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    task automatic do_load(input logic [H*W-1:0] d, input bit push);
        frame_t e;
        int t = 0;
        @(negedge clk);
        while (!load_ready && t < 600) begin
            @(negedge clk);
            t++;
        end
        load_valid = 1'b1;
        load_data  = d;
        if (push) begin
            for (int j = 0; j < H; j++) e.cnt[j] = int'(d[j*W +: W]);
            e.len = FL;
            exp_q.push_back(e);
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_frame(output bit got);
        got = 1'b0;
        for (int t = 0; t < 600 && !got; t++) begin
            if (obs_q.size() > 0) got = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_run(output bit got);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            #1;
            got = (run_q.size() > 0);
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #10;
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", load_ready); end
        vectors++; if (spikes !== 7'h00) begin miscompares++; $display("FAIL reset_spikes: got %h expected 00", spikes); end
        vectors++; if (frame_active !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %b expected 0", frame_active); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_frame;
        bit got;
        frame_t o, e;
        run_q.delete();
        do_load(pack(0, 255, 1, 128, 254, 2, 127), 1'b1);
        vectors++; if (spikes !== 7'b1111110) begin miscompares++; $display("FAIL first_spikes: got %b expected 1111110", spikes); end
        vectors++; if (frame_active !== 1'b1) begin miscompares++; $display("FAIL first_active: got %b expected 1", frame_active); end
        wait_frame(got);
        vectors++;
        if (!got) begin miscompares++; $display("FAIL frame_timeout: got no frame expected one"); end
        else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            for (int j = 0; j < H; j++) begin
                vectors++;
                if (o.cnt[j] !== e.cnt[j]) begin miscompares++; $display("FAIL frame_ch%0d: got %0d expected %0d", j, o.cnt[j], e.cnt[j]); end
            end
            vectors++; if (o.len !== e.len) begin miscompares++; $display("FAIL frame_len: got %0d expected %0d", o.len, e.len); end
            $display("frame: counts %0d %0d %0d %0d %0d %0d %0d len %0d", o.cnt[0], o.cnt[1], o.cnt[2], o.cnt[3], o.cnt[4], o.cnt[5], o.cnt[6], o.len);
        end
        wait_run(got);
        vectors++; if (!got || run_q[0] !== 255) begin miscompares++; $display("FAIL frame_run: got %0d expected 255", got ? run_q[0] : -1); end
        vectors++; if (spikes !== 7'h00 || frame_active !== 1'b0 || load_ready !== 1'b1)
            begin miscompares++; $display("FAIL frame_idle: got spikes %h active %b ready %b expected 00 0 1", spikes, frame_active, load_ready); end
    endtask

    task automatic test_back_to_back;
        bit got;
        frame_t o, e;
        int t = 0;
        logic [H*W-1:0] a, b;
        a = pack(10, 20, 30, 40, 50, 60, 70);
        b = pack(255, 0, 128, 64, 32, 16, 8);
        run_q.delete();
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = a;
        for (int j = 0; j < H; j++) e.cnt[j] = int'(a[j*W +: W]);
        e.len = FL; exp_q.push_back(e);
        @(negedge clk);
        load_data = b;
        while (!load_ready && t < 600) begin
            @(negedge clk);
            t++;
        end
        for (int j = 0; j < H; j++) e.cnt[j] = int'(b[j*W +: W]);
        exp_q.push_back(e);
        vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL b2b_done: got %b expected 1", frame_done); end
        @(negedge clk);
        load_valid = 1'b0;
        vectors++; if (frame_active !== 1'b1 || spikes !== 7'b1111101)
            begin miscompares++; $display("FAIL b2b_restart: got active %b spikes %b expected 1 1111101", frame_active, spikes); end
        for (int f = 0; f < 2; f++) begin
            wait_frame(got);
            vectors++;
            if (!got) begin miscompares++; $display("FAIL b2b_timeout: got no frame expected frame %0d", f); end
            else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                for (int j = 0; j < H; j++) begin
                    vectors++;
                    if (o.cnt[j] !== e.cnt[j]) begin miscompares++; $display("FAIL b2b_f%0d_ch%0d: got %0d expected %0d", f, j, o.cnt[j], e.cnt[j]); end
                end
                vectors++; if (o.len !== FL) begin miscompares++; $display("FAIL b2b_len: got %0d expected %0d", o.len, FL); end
                $display("b2b: frame %0d len %0d", f, o.len);
            end
        end
        wait_run(got);
        vectors++; if (!got || run_q[0] !== 510) begin miscompares++; $display("FAIL b2b_run: got %0d expected 510", got ? run_q[0] : -1); end
    endtask

    task automatic test_ignore;
        bit got;
        frame_t o, e;
        do_load(pack(5, 100, 200, 33, 77, 150, 250), 1'b1);
        repeat (100) @(negedge clk);
        vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL ignore_ready: got %b expected 0", load_ready); end
        load_valid = 1'b1;
        load_data  = pack(255, 255, 255, 255, 255, 255, 255);
        @(negedge clk);
        load_valid = 1'b0;
        wait_frame(got);
        vectors++;
        if (!got) begin miscompares++; $display("FAIL ignore_timeout: got no frame expected one"); end
        else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            for (int j = 0; j < H; j++) begin
                vectors++;
                if (o.cnt[j] !== e.cnt[j]) begin miscompares++; $display("FAIL ignore_ch%0d: got %0d expected %0d", j, o.cnt[j], e.cnt[j]); end
            end
            $display("ignore: frame len %0d", o.len);
        end
        repeat (5) @(negedge clk);
        vectors++; if (frame_active !== 1'b0) begin miscompares++; $display("FAIL ignore_idle: got %b expected 0", frame_active); end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        do_load(pack(255, 255, 255, 255, 255, 255, 255), 1'b0);
        repeat (60) @(negedge clk);
        vectors++; if (spikes !== 7'h7F) begin miscompares++; $display("FAIL mid_pre: got %h expected 7f", spikes); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (spikes !== 7'h00 || frame_active !== 1'b0 || frame_done !== 1'b0)
            begin miscompares++; $display("FAIL mid_async: got spikes %h active %b done %b expected 00 0 0", spikes, frame_active, frame_done); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %b expected 1", load_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (spikes !== 7'h00 || frame_active !== 1'b0 || load_ready !== 1'b1) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL mid_resume: got %0d active cycles expected 0", bad); end
        vectors++; if (obs_q.size() !== 0) begin miscompares++; $display("FAIL mid_frames: got %0d frames expected 0", obs_q.size()); end
        $display("reset_mid: aborted, %0d bad idle cycles", bad);
    endtask

    task automatic test_extremes;
        bit got;
        frame_t o, e;
        int v [2] = '{255, 0};
        for (int k = 0; k < 2; k++) begin
            do_load(pack(v[k], v[k], v[k], v[k], v[k], v[k], v[k]), 1'b1);
            wait_frame(got);
            vectors++;
            if (!got) begin miscompares++; $display("FAIL ext_timeout: got no frame expected value %0d", v[k]); end
            else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                for (int j = 0; j < H; j++) begin
                    vectors++;
                    if (o.cnt[j] !== e.cnt[j]) begin miscompares++; $display("FAIL ext%0d_ch%0d: got %0d expected %0d", v[k], j, o.cnt[j], e.cnt[j]); end
                end
                vectors++; if (o.len !== FL) begin miscompares++; $display("FAIL ext%0d_len: got %0d expected %0d", v[k], o.len, FL); end
                $display("extremes: value %0d ch0 %0d len %0d", v[k], o.cnt[0], o.len);
            end
        end
    endtask

    task automatic test_width3;
        logic [8:0] seen = '0;
        int dup = 0, ones4 = 0, done_err = 0, first = -1, l;
        @(negedge clk);
        vectors++; if (load_ready3 !== 1'b1) begin miscompares++; $display("FAIL w3_ready: got %b expected 1", load_ready3); end
        load_valid3 = 1'b1;
        load_data3  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        @(negedge clk);
        load_valid3 = 1'b0;
        // Channel j holds j+1, so the number of high channels is 8 - lfsr.
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            l = 8 - $countones(spikes3);
            if (c == 0) first = l;
            if (seen[l]) dup++;
            seen[l] = 1'b1;
            ones4 += int'(spikes3[3]);
            if (frame_done3 !== (c == 6)) done_err++;
        end
        vectors++; if (first !== 1) begin miscompares++; $display("FAIL w3_seed: got %0d expected 1", first); end
        vectors++; if (ones4 !== 4) begin miscompares++; $display("FAIL w3_ones: got %0d expected 4", ones4); end
        vectors++; if (seen !== 9'b011111110 || dup !== 0) begin miscompares++; $display("FAIL w3_cover: got %b dup %0d expected 011111110 dup 0", seen, dup); end
        vectors++; if (done_err !== 0) begin miscompares++; $display("FAIL w3_done: got %0d bad cycles expected 0", done_err); end
        @(negedge clk);
        vectors++; if (frame_active3 !== 1'b0) begin miscompares++; $display("FAIL w3_idle: got %b expected 0", frame_active3); end
        $display("width3: seen %b ones %0d", seen, ones4);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int j = 0; j < H; j++) acc.cnt[j] = 0;
        acc.len = 0;
        test_reset;
        test_frame;
        test_back_to_back;
        test_ignore;
        test_reset_mid;
        test_extremes;
        test_width3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and SHALL set the value width per channel, legal range 3..8.
REQ-002 The parameter HEIGHT SHALL default to 7 and SHALL set the number of spike channels, minimum 1.
REQ-003 The port clk SHALL be an input of width 1 and SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 The port rst SHALL be an input of width 1 and SHALL be the asynchronous, active-low reset.
REQ-005 The port load_valid SHALL be an input of width 1 and SHALL mean that load_data holds a frame request.
REQ-006 The port load_ready SHALL be an output of width 1 and SHALL mean that the encoder accepts a load in this cycle.
REQ-007 The port load_data SHALL be an input of width HEIGHT*WIDTH, with channel j at bits [j*WIDTH +: WIDTH], unsigned.
REQ-008 The port spikes SHALL be an output of width HEIGHT carrying one stochastic bit stream per channel.
REQ-009 The port frame_active SHALL be an output of width 1 and SHALL be high while a frame is being emitted.
REQ-010 The port frame_done SHALL be an output of width 1 and SHALL be high during the last cycle of each frame.

Function
REQ-011 FRAME_LEN SHALL equal 2^WIDTH-1 cycles.
REQ-012 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-013 A load SHALL be accepted on a rising edge where load_valid and load_ready are both high.
REQ-014 On acceptance: state=RUN, cnt=0, lfsr=1, and all HEIGHT values latched.
REQ-015 load_ready SHALL be 1 in IDLE, 1 in RUN when cnt==FRAME_LEN-1, and 0 otherwise.
REQ-016 load_valid while load_ready=0 SHALL be ignored, with no state change and no data capture.
REQ-017 lfsr SHALL be a WIDTH-bit maximal-length Fibonacci LFSR that advances every RUN cycle and visits 1..2^WIDTH-1 exactly once per frame.
REQ-018 spikes[j] SHALL be 1 iff state==RUN and lfsr <= val[j] (unsigned compare).
REQ-019 Per frame, channel j SHALL emit exactly val[j] ones: val=0 gives never high; val=2^WIDTH-1 gives high every frame cycle.
REQ-020 The first spike cycle SHALL be the cycle immediately after the acceptance edge, so load-to-spike latency is 1 edge.
REQ-021 cnt SHALL increment 0..FRAME_LEN-1 in RUN, with no wrap beyond FRAME_LEN-1.
REQ-022 frame_active SHALL equal (state==RUN).
REQ-023 frame_done SHALL equal (state==RUN && cnt==FRAME_LEN-1).
REQ-024 At cnt==FRAME_LEN-1 with an accepted load: the next frame SHALL start back-to-back with no idle cycle, cnt=0, lfsr=1, and new values.
REQ-025 At cnt==FRAME_LEN-1 without a load: state SHALL go to IDLE and spikes SHALL become 0.
REQ-026 In IDLE, spikes SHALL be all zeros regardless of the latched values.

Reset
REQ-027 rst=0 SHALL immediately force state=IDLE, cnt=0, lfsr=1, and all latched values=0, independent of clk.
REQ-028 During reset the outputs SHALL be: load_ready=1, spikes=0, frame_active=0, frame_done=0.
REQ-029 Reset mid-frame SHALL abort the frame, and no partial frame SHALL resume after rst returns to 1.
REQ-030 Loads SHALL be accepted only on edges where rst=1.

Structure
REQ-031 A shared package neuro_pkg SHALL hold the LFSR tap-mask function for WIDTH 3..8, FRAME_LEN, and the state enum.
REQ-032 The sub-module lfsr_gen (params WIDTH; ports clk, rst, clear, enable, value) SHALL implement the LFSR.
REQ-033 The comparators SHALL be a generate loop over HEIGHT in the top module.

Verification
REQ-034 Reset, then load {0,255,1,128,254,2,127} (WIDTH=8, HEIGHT=7) -> per-channel ones over 255 cycles = 0,255,1,128,254,2,127, and frame_done is high exactly once at cycle 255.
REQ-035 Hold load_valid high with two consecutive loads -> second frame starts in the cycle after frame_done, with 510 contiguous frame_active cycles and no gap.
REQ-036 Pulse load_valid with new data at cnt=100 -> data ignored, and first-frame counts unchanged.
REQ-037 Assert rst=0 at cnt=60 asynchronously between edges -> spikes=0 and frame_active=0 immediately, and after release load_ready=1 with no spikes until a new load.
REQ-038 Drive all values=255 -> spikes all-ones for 255 cycles; drive all values=0 -> spikes all-zeros with frame_active high for 255 cycles.
REQ-039 For WIDTH=3, load value 4 -> 4 ones in 7 cycles, and the LFSR sequence covers 1..7 with no repeats.
